seg7_scan_mux: RTL

Time-multiplexed 7-segment display driver, sitting directly downstream of the combinational BCD-number-to-7-segment converter. It accepts a packed N_DIG x 8-bit segment word through a valid/ready handshake and double-buffers it so display updates happen only at frame boundaries (no tearing). It then scans one digit at a time onto a shared segment bus with one-hot anode select, per-digit enable masking and PWM brightness control.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan_timer.sv | 62 ++++++
 rtl/seg7_scan_mux.sv | 106 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

  localparam int SEG_W = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Anode on-time in clock cycles for a brightness level. The product is
  // formed at 64 bits so large prescalers cannot overflow before the shift.
  function automatic logic [31:0] calc_on_time(input logic [31:0] bright,
                                               input int unsigned prescale,
                                               input int unsigned pwm_bits);
    logic [63:0] prod;
    prod = (64'(bright) + 64'd1) * 64'(prescale);
    return 32'(prod >> pwm_bits);
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer: cycle counter within a digit slot, digit index, per-slot
// brightness sample and end-of-frame strobe.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 1000,
  parameter int PWM_BITS = 3,
  localparam int IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] brightness_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                cnt_lt_on_o,
  output logic                at_boundary_o
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int OT_W  = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OT_W-1:0]  on_time_q, on_time_d;

  // Next-state: advance the slot counter, step the digit on wrap, and latch
  // the on-time at the start of each slot so it is stable for the slot.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    on_time_d = on_time_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    if (cnt_q == '0) begin
      on_time_d = OT_W'(calc_on_time(32'(brightness_i), PRESCALE, PWM_BITS));
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      on_time_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      on_time_q <= on_time_d;
    end
  end

  // On-time is always at least one cycle, so the first cycle of a slot is lit
  // using the live brightness while the latched copy covers the rest.
  assign cnt_lt_on_o   = (cnt_q == '0) || ({1'b0, cnt_q} < on_time_q);
  assign at_boundary_o = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
  assign idx_o         = idx_q;

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: double-buffered word intake with a
// valid/ready handshake, frame-aligned display swap, one-hot anode scan with
// per-digit enable and PWM brightness.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 1000,
  parameter int PWM_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEG_W*N_DIG-1:0] seg_in,
  input  logic                   seg_valid,
  output logic                   seg_ready,
  input  logic [N_DIG-1:0]       dig_en,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [SEG_W-1:0]       seg_out,
  output logic [N_DIG-1:0]       an_out,
  output logic                   frame_done
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [IDX_W-1:0] idx;
  logic             cnt_lt_on;
  logic             at_boundary;
  logic             accept;

  logic [SEG_W*N_DIG-1:0] shadow_q, shadow_d;
  logic [SEG_W*N_DIG-1:0] disp_q, disp_d;
  logic                   pending_q, pending_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [N_DIG-1:0]       an_q, an_d;
  logic                   frame_q, frame_d;

  seg7_scan_timer #(
    .N_DIG    (N_DIG),
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .brightness_i  (brightness),
    .idx_o         (idx),
    .cnt_lt_on_o   (cnt_lt_on),
    .at_boundary_o (at_boundary)
  );

  assign seg_ready = !rst && !pending_q;
  assign accept    = seg_valid && seg_ready;

  // Buffer control: swap the pending word in at the frame boundary; a new
  // word can only land when nothing is pending, so it never skips a frame.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (at_boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = seg_in;
      pending_d = 1'b1;
    end
  end

  // Output decode: light the current digit only inside its on-time window and
  // only if enabled; the segment bus is blanked whenever no anode is driven.
  always_comb begin
    an_d    = '0;
    seg_d   = SEG_BLANK;
    frame_d = at_boundary;
    for (int k = 0; k < N_DIG; k++) begin
      if ((IDX_W'(k) == idx) && cnt_lt_on && dig_en[k]) begin
        an_d[k] = 1'b1;
        seg_d   = disp_q[SEG_W*k +: SEG_W];
      end
    end
  end

  // Buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= '0;
      frame_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_q;

endmodule
